seq_coef_mult: RTL and testbench
================================

Name: seq_coef_mult

Overview:
- Parametrised successor to the team's fixed multiply-by-constant sequencer.
- Accepts one DW-bit sample through a valid/ready handshake.
- For each accepted sample, produces NCOEF products (sample x coefficient, one product per coefficient) in index order.
- Coefficients come from a selectable bank. Each product is computed by a serial shift-add engine, one coefficient bit per cycle, so no hardware multiplier is used.
- Sits between a sample source and a downstream consumer that can apply back-pressure.

Parameters:
- DW, 8: sample width.
- CW, 4: coefficient width; also the number of shift-add cycles per product.
- NCOEF, 4: coefficients per bank (products per sample).
- NBANK, 2: number of coefficient banks.
- COEFS, 32'hF642_8731: packed coefficient table, NBANK*NCOEF*CW bits. Entry [b][i] sits at bit offset (b*NCOEF+i)*CW. Default bank0 = 1,3,7,8; bank1 = 2,4,6,15.
- Derived localparams:
  - OW = DW+CW
  - IW = max(1, clog2(NCOEF))
  - BW = max(1, clog2(NBANK))

Ports:
- clk, input, 1: clock.
- rst, input, 1: reset, synchronous, active-high.
- in_valid, input, 1: in_data and in_bank are valid.
- in_ready, output, 1: block can accept a sample.
- in_data, input, DW: sample.
- in_bank, input, BW: coefficient bank for this sample.
- out_valid, output, 1: out_data, out_idx and out_last are valid.
- out_ready, input, 1: consumer accepts the output.
- out_data, output, OW: product, unsigned.
- out_idx, output, IW: coefficient index of this product.
- out_last, output, 1: this is the final product of the sample.
- busy, output, 1: state is not IDLE.

Behaviour:
- Clocking and reset:
  - Single clock. All state changes on the posedge of clk.
  - With rst=1 at an edge: state=IDLE; in_ready=1; out_valid=0; out_data=0; out_idx=0; out_last=0; busy=0; internal accumulator, bit counter, index and latched sample are cleared.
  - rst mid-operation discards the in-flight sample with no further outputs.
- States:
  - IDLE:
    - in_ready=1.
    - On in_valid: latch in_data and bank (in_bank >= NBANK maps to bank 0); set idx=0, acc=0, bit=0; go to CALC.
  - CALC:
    - in_ready=0, out_valid=0.
    - Each cycle: if coef[bank][idx][bit]=1, acc += (sample << bit). Then bit++.
    - On the cycle with bit==CW-1, go to OUT after the add.
    - Always exactly CW cycles; zero coefficient bits are not skipped.
  - OUT:
    - out_valid=1, out_data=acc, out_idx=idx, out_last=(idx==NCOEF-1).
    - All three outputs are held stable until out_ready.
    - On out_ready with out_last: go to IDLE.
    - On out_ready without out_last: idx++, acc=0, bit=0, go to CALC.
- Latency:
  - Accept at edge t gives out_valid visible after edge t+CW.
  - Output handshake at edge e gives the next out_valid after edge e+CW.
  - After the last handshake, in_ready=1 after the same edge.
  - Minimum sample period with out_ready tied high: NCOEF*(CW+1) cycles.
- Arithmetic:
  - Unsigned.
  - OW=DW+CW holds the maximum product (2^DW-1)*(2^CW-1) without overflow; no truncation.
- in_valid while in_ready=0 is ignored. No skid buffer; the source must hold the sample until accepted.
- out_ready while out_valid=0 is ignored.
- rst and in_valid in the same cycle: rst wins; nothing is accepted.
- busy is high in CALC and OUT.

Decomposition:
- Package seq_coef_mult_pkg holds:
  - state enum {IDLE, CALC, OUT}
  - default-parameter localparams
  - a function coef_at(COEFS, bank, idx) returning a CW-bit entry
- Sub-module serial_shift_add owns the shift-add datapath:
  - holds sample, acc and bit counter
  - ports: clk, rst, start, sample, coef, done, product
- The top level owns the FSM, the handshakes, index/bank sequencing and the output registers.

Test Plan:
- Defaults, out_ready=1, in_data=8'd5, in_bank=0 -> out_data 5,15,35,40 with out_idx 0..3, out_last only on idx 3; first out_valid 4 cycles after accept; next in_ready 20 cycles after accept.
- in_data=8'hFF, in_bank=1 -> out_data 510,1020,1530,3825 (the last is the max with no overflow); in_data=0 -> four zero products.
- Back-pressure: out_ready low for 10 cycles on idx 1 -> out_valid, out_data=15 (d=5, bank0) and out_idx held stable; no idx 2 until the handshake; in_valid pulses during the stall are not accepted.
- Assert rst for one cycle during CALC of idx 2 -> next cycle out_valid=0, in_ready=1, busy=0; the next sample d=3, bank0 yields 3,9,21,24 with out_idx restarting at 0.
- Back-to-back: in_valid held high with samples 1,2 -> second accept on the cycle in_ready returns, products 1,3,7,8 then 2,6,14,16, with no dropped or duplicated idx.
- Random in_data/in_bank/out_ready for 10k cycles -> scoreboard matches sample*coef for every product; out_data stable while out_valid && !out_ready.

Source files
------------

// File: rtl/seq_coef_mult_pkg.sv
// Shared types, default parameters and coefficient-table lookup for seq_coef_mult.
package seq_coef_mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    OUT  = 2'd2
  } state_t;

  localparam int          DEF_DW    = 8;
  localparam int          DEF_CW    = 4;
  localparam int          DEF_NCOEF = 4;
  localparam int          DEF_NBANK = 2;
  localparam logic [31:0] DEF_COEFS = 32'hF642_8731;

  // Upper bounds for the generic lookup below; tables wider than MAX_TBL bits
  // or coefficients wider than MAX_CW bits are not supported.
  localparam int MAX_TBL = 1024;
  localparam int MAX_CW  = 32;

  // Extract entry [bank][idx] from a packed table whose entries are cw bits
  // wide and laid out at bit offset (bank*ncoef+idx)*cw.
  function automatic logic [MAX_CW-1:0] coef_at(
    input logic [MAX_TBL-1:0] coefs,
    input int                 bank,
    input int                 idx,
    input int                 ncoef,
    input int                 cw
  );
    logic [MAX_TBL-1:0] shifted;
    logic [MAX_CW-1:0]  mask;
    shifted = coefs >> ((bank * ncoef + idx) * cw);
    mask    = (MAX_CW'(1) << cw) - MAX_CW'(1);
    return shifted[MAX_CW-1:0] & mask;
  endfunction

endpackage

// File: rtl/serial_shift_add.sv
// Serial shift-add multiplier: one coefficient bit per cycle, CW cycles per product.
module serial_shift_add
  import seq_coef_mult_pkg::*;
#(
  parameter  int DW  = DEF_DW,
  parameter  int CW  = DEF_CW,
  localparam int OW  = DW + CW,
  localparam int CBW = (CW > 1) ? $clog2(CW) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [DW-1:0] sample,
  input  logic [CW-1:0] coef,
  output logic          done,
  output logic [OW-1:0] product
);

  logic [DW-1:0]  sample_reg;
  logic [OW-1:0]  acc_reg;
  logic [CBW-1:0] bit_reg;
  logic           run_reg;
  logic           last_bit;
  logic [OW-1:0]  addend;

  assign last_bit = (bit_reg == CBW'(CW - 1));
  assign addend   = OW'(sample_reg) << bit_reg;
  // done marks the cycle whose edge performs the final add
  assign done     = run_reg && last_bit;
  assign product  = acc_reg;

  // start clears the accumulator and latches the sample; every running cycle
  // conditionally adds the shifted sample, never skipping zero bits
  always_ff @(posedge clk) begin
    if (rst) begin
      sample_reg <= '0;
      acc_reg    <= '0;
      bit_reg    <= '0;
      run_reg    <= 1'b0;
    end else if (start) begin
      sample_reg <= sample;
      acc_reg    <= '0;
      bit_reg    <= '0;
      run_reg    <= 1'b1;
    end else if (run_reg) begin
      if (coef[bit_reg]) begin
        acc_reg <= acc_reg + addend;
      end
      if (last_bit) begin
        run_reg <= 1'b0;
      end else begin
        bit_reg <= bit_reg + CBW'(1);
      end
    end
  end

endmodule

// File: rtl/seq_coef_mult.sv
// Sequential multiply-by-coefficient-bank: one sample in, NCOEF products out.
module seq_coef_mult
  import seq_coef_mult_pkg::*;
#(
  parameter  int                          DW    = DEF_DW,
  parameter  int                          CW    = DEF_CW,
  parameter  int                          NCOEF = DEF_NCOEF,
  parameter  int                          NBANK = DEF_NBANK,
  parameter  logic [NBANK*NCOEF*CW-1:0]   COEFS = DEF_COEFS,
  localparam int                          OW    = DW + CW,
  localparam int                          IW    = (NCOEF > 1) ? $clog2(NCOEF) : 1,
  localparam int                          BW    = (NBANK > 1) ? $clog2(NBANK) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  input  logic [BW-1:0] in_bank,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [OW-1:0] out_data,
  output logic [IW-1:0] out_idx,
  output logic          out_last,
  output logic          busy
);

  state_t            state_reg, state_next;
  logic [IW-1:0]     idx_reg;
  logic [BW-1:0]     bank_reg;
  logic [DW-1:0]     sample_reg;
  logic              accept;
  logic              advance;
  logic              start;
  logic              done;
  logic              last;
  logic [BW-1:0]     bank_sel;
  logic [DW-1:0]     engine_sample;
  logic [MAX_CW-1:0] coef_full;
  logic [CW-1:0]     coef;
  logic [OW-1:0]     product;

  // Out-of-range bank requests fall back to bank 0
  assign bank_sel      = (int'(in_bank) >= NBANK) ? '0 : in_bank;
  assign last          = (idx_reg == IW'(NCOEF - 1));
  // On accept the engine takes the incoming sample directly; later products reuse the latched one
  assign engine_sample = accept ? in_data : sample_reg;
  assign coef_full     = coef_at(MAX_TBL'(COEFS), int'(bank_reg), int'(idx_reg), NCOEF, CW);
  assign coef          = coef_full[CW-1:0];

  assign in_ready  = (state_reg == IDLE);
  assign out_valid = (state_reg == OUT);
  assign out_last  = (state_reg == OUT) && last;
  assign out_idx   = idx_reg;
  assign out_data  = product;
  assign busy      = (state_reg != IDLE);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic and engine start/sequencing strobes
  always_comb begin
    state_next = state_reg;
    accept     = 1'b0;
    advance    = 1'b0;
    start      = 1'b0;
    case (state_reg)
      IDLE: begin
        if (in_valid) begin
          accept     = 1'b1;
          start      = 1'b1;
          state_next = CALC;
        end
      end
      CALC: begin
        if (done) begin
          state_next = OUT;
        end
      end
      OUT: begin
        if (out_ready) begin
          if (last) begin
            state_next = IDLE;
          end else begin
            advance    = 1'b1;
            start      = 1'b1;
            state_next = CALC;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Sample, bank and coefficient index sequencing
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_reg    <= '0;
      bank_reg   <= '0;
      sample_reg <= '0;
    end else if (accept) begin
      idx_reg    <= '0;
      bank_reg   <= bank_sel;
      sample_reg <= in_data;
    end else if (advance) begin
      idx_reg    <= idx_reg + IW'(1);
    end
  end

  serial_shift_add #(
    .DW(DW),
    .CW(CW)
  ) u_engine (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .sample (engine_sample),
    .coef   (coef),
    .done   (done),
    .product(product)
  );

endmodule

// File: tb/tb_seq_coef_mult.sv
// Scoreboard testbench for seq_coef_mult with default parameters.
module tb_seq_coef_mult;

  localparam int DW    = 8;
  localparam int CW    = 4;
  localparam int NCOEF = 4;
  localparam int NBANK = 2;
  localparam int OW    = DW + CW;
  localparam int IW    = 2;
  localparam int BW    = 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic [BW-1:0] in_bank;
  logic          out_valid;
  logic          out_ready;
  logic [OW-1:0] out_data;
  logic [IW-1:0] out_idx;
  logic          out_last;
  logic          busy;

  always #5 clk = ~clk;

  seq_coef_mult dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_bank  (in_bank),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_idx  (out_idx),
    .out_last (out_last),
    .busy     (busy)
  );

  typedef struct packed {
    logic [OW-1:0] data;
    logic [IW-1:0] idx;
    logic          last;
  } exp_t;

  exp_t sb[$];

  // Reference coefficient banks, written out independently of the packed table
  int coef_tbl [NBANK][NCOEF] = '{'{1, 3, 7, 8}, '{2, 4, 6, 15}};

  int            n_checks = 0;
  int            n_pass   = 0;
  int            cyc      = 0;
  int            acc_edge = 0;
  bit            acc_flag = 1'b0;
  bit            stall_prev = 1'b0;
  logic [OW-1:0] data_prev;
  logic [IW-1:0] idx_prev;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Evaluate handshakes on the current (pre-edge) values, then advance one clock
  task automatic step();
    exp_t e;
    int   b;
    acc_flag = 1'b0;
    if (!rst) begin
      if (stall_prev) begin
        check("hold_valid", 32'(out_valid), 32'd1);
        check("hold_data", 32'(out_data), 32'(data_prev));
        check("hold_idx", 32'(out_idx), 32'(idx_prev));
      end
      if (in_valid && in_ready) begin
        b = (int'(in_bank) >= NBANK) ? 0 : int'(in_bank);
        for (int i = 0; i < NCOEF; i++) begin
          e.data = OW'(int'(in_data) * coef_tbl[b][i]);
          e.idx  = IW'(i);
          e.last = (i == NCOEF - 1);
          sb.push_back(e);
        end
        acc_flag = 1'b1;
        acc_edge = cyc + 1;
        $display("sample d=%0d bank=%0d edge=%0d", in_data, in_bank, acc_edge);
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("sb_unexpected", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          check("prod_data", 32'(out_data), 32'(e.data));
          check("prod_idx", 32'(out_idx), 32'(e.idx));
          check("prod_last", 32'(out_last), 32'(e.last));
        end
      end
    end
    stall_prev = !rst && out_valid && !out_ready;
    data_prev  = out_data;
    idx_prev   = out_idx;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic send(input logic [DW-1:0] d, input logic [BW-1:0] b);
    int n = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_bank  = b;
    forever begin
      step();
      if (acc_flag) break;
      n++;
      if (n > 200) begin
        check("send_timeout", 32'd0, 32'd1);
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((sb.size() != 0 || !in_ready) && n < budget) begin
      step();
      n++;
    end
    if (n >= budget) check("drain_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_idx(input logic [IW-1:0] want);
    int n = 0;
    while (!(out_valid && out_idx == want) && n < 100) begin
      step();
      n++;
    end
    if (n >= 100) check("wait_idx_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int t0;
    int n;
    int ready_cyc;
    bit ready_seen;

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_bank   = '0;
    out_ready = 1'b0;
    #1;
    step();
    step();

    // Reset state
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_idx", 32'(out_idx), 32'd0);
    check("rst_out_last", 32'(out_last), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    step();

    // Basic product sequence with latency measurement
    out_ready = 1'b1;
    send(8'd5, 1'b0);
    t0 = acc_edge;
    check("busy_after_accept", 32'(busy), 32'd1);
    n = 0;
    while (!out_valid && n < 50) begin
      step();
      n++;
    end
    check("first_valid_latency", 32'(cyc - t0), 32'(CW));
    n = 0;
    while (!in_ready && n < 100) begin
      step();
      n++;
    end
    check("in_ready_latency", 32'(cyc - t0), 32'(NCOEF * (CW + 1)));
    check("sb_empty_1", 32'(sb.size()), 32'd0);

    // Largest operands and zero sample
    send(8'hFF, 1'b1);
    drain(200);
    send(8'd0, 1'b0);
    drain(200);

    // Back-pressure on index 1
    out_ready = 1'b1;
    send(8'd5, 1'b0);
    wait_idx(2'd0);
    step();
    out_ready = 1'b0;
    n = 0;
    while (!out_valid && n < 50) begin
      step();
      n++;
    end
    check("stall_idx_first", 32'(out_idx), 32'd1);
    check("stall_data_first", 32'(out_data), 32'd15);
    for (int k = 0; k < 10; k++) begin
      in_valid = (k % 2 == 0);
      in_data  = 8'd99;
      step();
      check("stall_valid", 32'(out_valid), 32'd1);
      check("stall_idx", 32'(out_idx), 32'd1);
      check("stall_data", 32'(out_data), 32'd15);
      check("stall_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    drain(200);

    // Reset during CALC of index 2
    send(8'd5, 1'b0);
    wait_idx(2'd1);
    step();
    step();
    check("pre_rst_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("post_rst_out_valid", 32'(out_valid), 32'd0);
    check("post_rst_in_ready", 32'(in_ready), 32'd1);
    check("post_rst_busy", 32'(busy), 32'd0);
    sb.delete();
    send(8'd3, 1'b0);
    drain(200);

    // Back-to-back samples with in_valid held high
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 8'd1;
    in_bank   = 1'b0;
    n = 0;
    do begin
      step();
      n++;
    end while (!acc_flag && n < 50);
    t0         = acc_edge;
    in_data    = 8'd2;
    ready_seen = 1'b0;
    ready_cyc  = 0;
    n = 0;
    forever begin
      if (in_ready && !ready_seen) begin
        ready_seen = 1'b1;
        ready_cyc  = cyc;
      end
      step();
      if (acc_flag) break;
      n++;
      if (n > 100) begin
        check("b2b_timeout", 32'd0, 32'd1);
        break;
      end
    end
    in_valid = 1'b0;
    check("b2b_ready_return", 32'(ready_cyc - t0), 32'(NCOEF * (CW + 1)));
    check("b2b_accept_at_ready", 32'(acc_edge), 32'(ready_cyc + 1));
    drain(200);

    // Random traffic with random back-pressure
    acc_flag = 1'b0;
    for (int k = 0; k < 10000; k++) begin
      if (!in_valid || acc_flag) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_data  = DW'($urandom);
        in_bank  = BW'($urandom_range(0, 1));
      end
      out_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    drain(500);
    check("final_sb_empty", 32'(sb.size()), 32'd0);
    check("final_idle", 32'(busy), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
